// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and the execute-stage payload.
// Also used by ALU control, so the encodings here are the single source of truth.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] result;
        logic                zero;
        logic                illegal;
        logic [RD_W_DEF-1:0] rd;
        logic                reg_write;
    } ex_payload_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: decode-side valid/ready input, MEM-side valid/ready output, flush.
// A transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface alu_exec_stage_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [3:0]      ctrl_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [RD_W-1:0] rd_i;
    logic            reg_write_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic [RD_W-1:0] rd_o;
    logic            reg_write_o;
    logic            illegal_o;

    modport master (
        output flush_i, in_valid_i, ctrl_i, op_a_i, op_b_i, rd_i, reg_write_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, rd_o, reg_write_o, illegal_o
    );

    modport slave (
        input  flush_i, in_valid_i, ctrl_i, op_a_i, op_b_i, rd_i, reg_write_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, rd_o, reg_write_o, illegal_o
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: ctrl/op_a/op_b to result, zero flag and illegal-code flag.
// Define ALU_SLT_EN to build the signed set-less-than comparator for code 4'b0111.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      i_ctrl,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_illegal
);

    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_ctrl)
            ALU_AND: o_result = i_op_a & i_op_b;
            ALU_OR:  o_result = i_op_a | i_op_b;
            ALU_ADD: o_result = i_op_a + i_op_b;
            ALU_SUB: o_result = i_op_a - i_op_b;
`ifdef ALU_SLT_EN
            ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
`endif
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU compute on the input side, then a 2-entry (output M + skid S) buffer toward MEM.
// in_ready_o is registered so MEM back-pressure never reaches decode combinationally. Build option: ALU_SLT_EN.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input logic             clk_i,
    input logic             rst_i,
    alu_exec_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        logic [RD_W-1:0] rd;
        logic            reg_write;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{result: '0, zero: 1'b1, illegal: 1'b0, rd: '0, reg_write: 1'b0};

    logic            r_m_valid;
    logic            r_s_valid;
    logic            r_in_ready;
    entry_t          r_m;
    entry_t          r_s;

    logic [XLEN-1:0] w_result;
    logic            w_zero;
    logic            w_illegal;
    entry_t          w_new;
    logic            w_accept;
    logic            w_drain;
    logic            w_m_valid_nxt;
    logic            w_s_valid_nxt;
    entry_t          w_m_nxt;
    entry_t          w_s_nxt;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .i_ctrl    (bus.ctrl_i),
        .i_op_a    (bus.op_a_i),
        .i_op_b    (bus.op_b_i),
        .o_result  (w_result),
        .o_zero    (w_zero),
        .o_illegal (w_illegal)
    );

    // An illegal op still flows through so the trap logic downstream sees it, but must not write back.
    assign w_new = '{result: w_result, zero: w_zero, illegal: w_illegal,
                     rd: bus.rd_i, reg_write: bus.reg_write_i & ~w_illegal};

    assign w_accept = bus.in_valid_i & r_in_ready & ~bus.flush_i;
    assign w_drain  = r_m_valid & bus.out_ready_i;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_nxt       = r_m;
        w_s_nxt       = r_s;
        if (bus.flush_i) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (!r_m_valid || w_drain) begin
            if (r_s_valid) begin
                // in_ready_o is low whenever S is full, so no accept can collide with this move.
                w_m_nxt       = r_s;
                w_m_valid_nxt = 1'b1;
                w_s_valid_nxt = 1'b0;
            end else begin
                w_m_valid_nxt = w_accept;
                if (w_accept) begin
                    w_m_nxt = w_new;
                end
            end
        end else if (w_accept) begin
            w_s_nxt       = w_new;
            w_s_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_m        <= RESET_ENTRY;
            r_s        <= RESET_ENTRY;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= ~w_s_valid_nxt;
            r_m        <= w_m_nxt;
            r_s        <= w_s_nxt;
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.out_valid_o = r_m_valid;
    assign bus.result_o    = r_m.result;
    assign bus.zero_o      = r_m.zero;
    assign bus.illegal_o   = r_m.illegal;
    assign bus.rd_o        = r_m.rd;
    assign bus.reg_write_o = r_m.reg_write;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath that sits directly downstream of ALU control. It consumes the 4-bit ALU control code plus two XLEN operands, computes the result, and registers it toward the MEM stage.
- Valid/ready handshake on both sides.
- A 2-entry buffer (output register plus skid register) gives full throughput with a registered in_ready_o, so MEM back-pressure never combinationally reaches the decode stage.
- Flush input discards in-flight ops on branch mispredict or trap.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered ops and any op offered this cycle.
- in_valid_i  in  1  upstream op valid.
- in_ready_o  out  1  stage can accept (registered).
- ctrl_i  in  4  ALU control code.
- op_a_i  in  XLEN  operand A (rs1).
- op_b_i  in  XLEN  operand B (rs2 or imm).
- rd_i  in  RD_W  destination register.
- reg_write_i  in  1  writeback enable.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- result_o  out  XLEN  ALU result.
- zero_o  out  1  result_o == 0, used for branches.
- rd_o  out  RD_W  destination register.
- reg_write_o  out  1  writeback enable, forced 0 when illegal_o=1.
- illegal_o  out  1  ctrl_i was not a supported code.

Behaviour:
- Control codes:
  - 4'b0000 AND.
  - 4'b0001 OR.
  - 4'b0010 ADD.
  - 4'b0110 SUB.
  - 4'b0111 SLT (only when ALU_SLT_EN is defined).
  - Any other code: result 0, illegal=1.
- Arithmetic: ADD/SUB are modulo 2^XLEN, carry/borrow discarded. zero is computed on the final XLEN-bit result.
- Compute is combinational on the input side. Result, zero, illegal, rd and reg_write are captured together at accept time.
- Accept: in_valid_i & in_ready_o & ~flush_i.
- Storage:
  - M = output register, drives the out_* ports.
  - S = skid register.
  - in_ready_o = ~S.valid, registered.
- Latency: accept in cycle N gives out_valid_o=1 in cycle N+1. Throughput is 1 op/cycle while out_ready_i=1.
- Per-cycle update, where drain = out_valid_o & out_ready_i:
  - M empty or drain, S empty: accepted op loads M. With no accept, M.valid clears after drain.
  - M full, no drain, accept: op loads S, and in_ready_o drops next cycle.
  - drain with S full: S moves to M, S clears, in_ready_o rises next cycle. No accept is possible that cycle because in_ready_o=0.
  - Order is strictly preserved; S never overtakes M.
- Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Flush (priority over everything except reset):
  - Next cycle: M.valid=0, S.valid=0, in_ready_o=1.
  - An op offered in the flush cycle is dropped.
  - A drain in the same cycle still counts as delivered.
- Reset:
  - All valids=0, in_ready_o=1.
  - result_o=0, zero_o=1, rd_o=0, reg_write_o=0, illegal_o=0.
  - Reset mid-transfer discards everything.
- Payload registers load only on accept or S-to-M move. Idle cycles do not toggle data.

Optional Feature:
- Macro: ALU_SLT_EN.
- Defined: code 4'b0111 computes signed op_a < op_b, giving result {XLEN-1 zeros, lt}, illegal=0.
- Undefined: 4'b0111 is illegal (result 0, illegal_o=1, reg_write_o=0). The comparator is not synthesized.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [3:0] alu_ctrl_e {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT}, shared with ALU control.
  - XLEN_DEF constant.
  - struct ex_payload_t {result, zero, illegal, rd, reg_write}.
- One natural sub-module, alu_core: purely combinational ctrl/op_a/op_b to result/zero/illegal. It is instantiated once. The parent owns the M/S buffer and handshake.

Test Plan:
- Reset then idle: in_ready_o=1, out_valid_o=0, zero_o=1, result_o=0.
- ADD 0xFFFFFFFF + 1 (rd=3, reg_write=1), out_ready_i=1: next cycle result 0, zero 1, rd_o=3. SUB 5-7 gives 0xFFFFFFFE. AND/OR 0xF0F0 with 0x0FF0 give 0x00F0 / 0xFFF0.
- Back-pressure: stream 4 ADDs with out_ready_i held 0. Two are captured (M, S), in_ready_o falls after the second. Release out_ready_i: all 4 emerge in order, no loss or duplication.
- Flush with M and S full while offering a new op: next cycle out_valid_o=0, in_ready_o=1, offered op never appears.
- ctrl 4'b0111, op_a=-1, op_b=1: with ALU_SLT_EN, result 1, illegal 0. Without it, result 0, illegal 1, reg_write_o 0. ctrl 4'b1111 is always illegal.
- Random valid/ready toggling for 10k ops against a reference queue: in-order, exact-once delivery; outputs stable during stall; reset asserted mid-stream clears all valids.
